// File: rtl/reg_bank_if.sv
// Bus bundle for reg_bank: write/read/increment/clear command lines and the read-back outputs.
// The control unit drives the master side. The register bank implements the slave side.
interface reg_bank_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_en;
  logic [ADDR_WIDTH-1:0] read_addr_a;
  logic [ADDR_WIDTH-1:0] read_addr_b;
  logic [DATA_WIDTH-1:0] data_out_a;
  logic [DATA_WIDTH-1:0] data_out_b;
  logic                  inc_en;
  logic [ADDR_WIDTH-1:0] inc_addr;
  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  inc_wrap;
  logic [DATA_WIDTH-1:0] store;

  modport master (
    output write_en, write_addr, data_in, read_en, read_addr_a, read_addr_b,
           inc_en, inc_addr, clr_en, clr_addr,
    input  data_out_a, data_out_b, inc_wrap, store
  );

  modport slave (
    input  write_en, write_addr, data_in, read_en, read_addr_a, read_addr_b,
           inc_en, inc_addr, clr_en, clr_addr,
    output data_out_a, data_out_b, inc_wrap, store
  );
endinterface

// File: rtl/reg_bank.sv
// Datapath register bank: one write port, two registered write-first read ports, per-register increment and clear.
// Define REG_BANK_ZERO_REG_EN to hard-wire register 0 to zero.
module reg_bank #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    NUM_REGS   = 8,
  parameter int                    ADDR_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_bank_if.slave  bus
);

`ifdef REG_BANK_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_next [NUM_REGS];
  logic [NUM_REGS-1:0]   w_wrap_hit;
  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;
  logic [DATA_WIDTH-1:0] w_store;
  logic [DATA_WIDTH-1:0] r_data_out_a;
  logic [DATA_WIDTH-1:0] r_data_out_b;
  logic                  r_inc_wrap;

  function automatic logic is_live(input int idx);
    return !(ZERO_REG && idx == 0);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] inc_val(input logic [DATA_WIDTH-1:0] v);
    return v + DATA_WIDTH'(1);
  endfunction

  // Next state per register: clear beats write beats increment
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_next[i]     = r_regs[i];
      w_wrap_hit[i] = 1'b0;
      if (is_live(i)) begin
        if (bus.clr_en && bus.clr_addr == ADDR_WIDTH'(i)) begin
          w_next[i] = RST_VAL;
        end else if (bus.write_en && bus.write_addr == ADDR_WIDTH'(i)) begin
          w_next[i] = bus.data_in;
        end else if (bus.inc_en && bus.inc_addr == ADDR_WIDTH'(i)) begin
          w_next[i]     = inc_val(r_regs[i]);
          w_wrap_hit[i] = &r_regs[i];
        end
      end
    end
  end

  // Read muxes; unmatched (out-of-range or hard-zero) addresses fall through to 0
  always_comb begin
    w_rd_a  = '0;
    w_rd_b  = '0;
    w_store = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (is_live(i) && bus.read_addr_a == ADDR_WIDTH'(i)) begin
        w_rd_a  = w_next[i];
        w_store = r_regs[i];
      end
      if (is_live(i) && bus.read_addr_b == ADDR_WIDTH'(i)) begin
        w_rd_b = w_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RST_VAL;
      end
      r_data_out_a <= '0;
      r_data_out_b <= '0;
      r_inc_wrap   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= w_next[i];
      end
      r_inc_wrap <= |w_wrap_hit;
      if (bus.read_en) begin
        r_data_out_a <= w_rd_a;
        r_data_out_b <= w_rd_b;
      end
    end
  end

  assign bus.data_out_a = r_data_out_a;
  assign bus.data_out_b = r_data_out_b;
  assign bus.inc_wrap   = r_inc_wrap;
  assign bus.store      = w_store;

endmodule
